// File: rtl/regfile_pkg.sv
// Shared constants and reset-content helper for the decode-stage register file.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Register idx resets to its own index below init_ident, else 0.
  function automatic int unsigned init_val(int idx, int init_ident, bit zero_reg);
    if (zero_reg && idx == 0) return 0;
    return (idx < init_ident) ? int'(unsigned'(idx)) : 0;
  endfunction
endpackage

// File: rtl/sb_tracker.sv
// Destination scoreboard: per-register pending bits with flush > issue > write-back
// priority, plus a registered popcount that tracks the same edge.
module sb_tracker #(
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   flush,
  output logic [2**ADDR_W-1:0]   pending,
  output logic [ADDR_W:0]        pend_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_ok, iss_ok;

  assign wr_ok  = wr_en  & ~(ZERO_REG && wr_addr  == '0);
  assign iss_ok = iss_en & ~(ZERO_REG && iss_addr == '0);

  always_comb begin
    pend_d = pend_q;
    if (wr_ok)  pend_d[wr_addr]  = 1'b0;
    // A new producer overrides a same-cycle write-back of the old one.
    if (iss_ok) pend_d[iss_addr] = 1'b1;
    if (flush)  pend_d = '0;
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + CW'(pend_d[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending  = pend_q;
  assign pend_cnt = cnt_q;
endmodule

// File: rtl/regfile_sb.sv
// Register file with write-first bypass, registered read ports and an integrated
// destination scoreboard for RAW stall detection in decode.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int NUM_RD     = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter int INIT_IDENT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  input  logic                       flush,
  output logic [ADDR_W:0]            pend_cnt
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DEPTH-1:0]             pending;
  logic                         wr_ok;

  assign wr_ok = wr_en & ~(ZERO_REG && wr_addr == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(init_val(i, INIT_IDENT, ZERO_REG));
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  sb_tracker #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .flush    (flush),
    .pending  (pending),
    .pend_cnt (pend_cnt)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;

    assign ra  = rd_addr[p*ADDR_W +: ADDR_W];
    assign hit = wr_ok && (wr_addr == ra);

    // Busy samples pending before this edge's issue; a same-edge write-back clears it.
    always_comb begin
      data_d = data_q;
      busy_d = busy_q;
      if (rd_en[p]) begin
        data_d = hit ? wr_data : mem_q[ra];
        busy_d = pending[ra] & ~hit;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else begin
        data_q <= data_d;
        busy_q <= busy_d;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = data_q;
    assign rd_busy[p]                  = busy_q;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with four read ports; read expectations are queued
// when a read is driven and checked after the capturing edge.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              flush;
  logic [AW:0]       pend_cnt;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .INIT_IDENT(15)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .pend_cnt(pend_cnt)
  );

  typedef struct {
    string          tag;
    int             port;
    logic [DW-1:0]  d;
    logic           b;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_en = '0; wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
  endtask

  task automatic rd(input string tag, input int p, input int a, input logic [DW-1:0] d, input logic b);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
    sbq.push_back('{tag, p, d, b});
  endtask

  task automatic hold(input string tag, input int p, input logic [DW-1:0] d, input logic b);
    sbq.push_back('{tag, p, d, b});
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
  endtask

  task automatic iss(input int a);
    iss_en = 1'b1; iss_addr = AW'(a);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk({e.tag, ".data"}, 64'(rd_data[e.port*DW +: DW]), 64'(e.d));
      chk({e.tag, ".busy"}, 64'(rd_busy[e.port]), 64'(e.b));
    end
    idle();
  endtask

  initial begin
    reset = 1'b0; idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; iss_addr = '0;
    #12;
    chk("rst_data", 64'(rd_data[63:0]), 64'h0);
    chk("rst_busy", 64'(rd_busy), 64'h0);
    chk("rst_cnt",  64'(pend_cnt), 64'h0);
    @(negedge clk) reset = 1'b1;

    rd("r5", 0, 5, 32'd5, 1'b0); rd("r20", 1, 20, 32'd0, 1'b0);
    rd("r14", 2, 14, 32'd14, 1'b0); rd("r15", 3, 15, 32'd0, 1'b0);
    step();
    rd("r0_init", 0, 0, 32'd0, 1'b0);
    step();

    wr(7, 32'hDEADBEEF); rd("r7_byp", 0, 7, 32'hDEADBEEF, 1'b0);
    step();
    rd("r7_arr", 1, 7, 32'hDEADBEEF, 1'b0); hold("p0_hold", 0, 32'hDEADBEEF, 1'b0);
    step();

    wr(0, 32'h1234); rd("r0_wr_same", 0, 0, 32'd0, 1'b0);
    step();
    rd("r0_after", 0, 0, 32'd0, 1'b0); iss(0);
    step();
    chk("cnt_iss_r0", 64'(pend_cnt), 64'd0);

    iss(3); rd("r3_iss_same", 2, 3, 32'd3, 1'b0);
    step();
    chk("cnt_iss_r3", 64'(pend_cnt), 64'd1);
    rd("r3_busy", 0, 3, 32'd3, 1'b1); hold("p1_hold", 1, 32'hDEADBEEF, 1'b0);
    step();
    chk("cnt_r3_hold", 64'(pend_cnt), 64'd1);
    wr(3, 32'd9); rd("r3_wb", 0, 3, 32'd9, 1'b0);
    step();
    chk("cnt_r3_wb", 64'(pend_cnt), 64'd0);
    rd("r3_arr", 3, 3, 32'd9, 1'b0);
    step();

    iss(4); wr(4, 32'd1);
    step();
    chk("cnt_iss_wr_r4", 64'(pend_cnt), 64'd1);
    rd("r4_busy", 0, 4, 32'd1, 1'b1);
    step();
    flush = 1'b1; iss(6); rd("r6_flush_same", 1, 6, 32'd6, 1'b0);
    step();
    chk("cnt_flush", 64'(pend_cnt), 64'd0);
    rd("r6_after", 0, 6, 32'd6, 1'b0); rd("r4_after", 1, 4, 32'd1, 1'b0);
    step();

    iss(1);
    step();
    iss(2);
    step();
    chk("cnt_r1r2", 64'(pend_cnt), 64'd2);
    rd("q_r1", 0, 1, 32'd1, 1'b1); rd("q_r2", 1, 2, 32'd2, 1'b1);
    rd("q_r7", 2, 7, 32'hDEADBEEF, 1'b0); rd("q_r3", 3, 3, 32'd9, 1'b0);
    step();
    #2 reset = 1'b0;
    #1;
    chk("midrst_data_lo", 64'(rd_data[63:0]), 64'h0);
    chk("midrst_data_hi", 64'(rd_data[127:64]), 64'h0);
    chk("midrst_busy", 64'(rd_busy), 64'h0);
    chk("midrst_cnt", 64'(pend_cnt), 64'h0);
    @(negedge clk) reset = 1'b1;
    rd("post_r1", 0, 1, 32'd1, 1'b0); rd("post_r2", 1, 2, 32'd2, 1'b0);
    rd("post_r7", 2, 7, 32'd7, 1'b0); rd("post_r3", 3, 3, 32'd3, 1'b0);
    step();
    chk("post_cnt", 64'(pend_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
